// File: rtl/pwm_pkg.sv
// Shared constants and enums for the multi-channel PWM generator.
// Optional polarity register is enabled with `define PWM_POLARITY_EN.
package pwm_pkg;

  localparam int ADDR_PERIOD       = 0;
  localparam int ADDR_PRESCALE     = 1;
  localparam int ADDR_DUTY_BASE    = 2;
  // POLARITY lives just above the last duty register: CHANNELS + ADDR_POLARITY_OFS
  localparam int ADDR_POLARITY_OFS = 2;

  typedef enum logic {MODE_EDGE = 1'b0, MODE_CENTER = 1'b1} mode_e;
  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: double-buffered duty (and polarity when PWM_POLARITY_EN
// is defined), unsigned compare against the shared counter, registered output.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             load,
  input  logic             duty_we,
  input  logic [WIDTH-1:0] duty_data,
`ifdef PWM_POLARITY_EN
  input  logic             pol_we,
  input  logic             pol_data,
`endif
  input  logic [WIDTH-1:0] cnt,
  output logic             pwm_out
);

  logic [WIDTH-1:0] duty_stg_reg;
  logic [WIDTH-1:0] duty_stg_next;
  logic [WIDTH-1:0] duty_act_reg;
  logic             pol_act;
  logic             raw;
  logic             pwm_reg;

  // A write in the same cycle as a load goes straight through to the active copy.
  assign duty_stg_next = duty_we ? duty_data : duty_stg_reg;
  assign raw           = (cnt < duty_act_reg);
  assign pwm_out       = pwm_reg;

`ifdef PWM_POLARITY_EN
  logic pol_stg_reg;
  logic pol_stg_next;
  logic pol_act_reg;

  assign pol_stg_next = pol_we ? pol_data : pol_stg_reg;
  assign pol_act      = pol_act_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pol_stg_reg <= 1'b0;
      pol_act_reg <= 1'b0;
    end else begin
      pol_stg_reg <= pol_stg_next;
      if (load) pol_act_reg <= pol_stg_next;
    end
  end
`else
  assign pol_act = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_stg_reg <= '0;
      duty_act_reg <= '0;
      pwm_reg      <= 1'b0;
    end else begin
      duty_stg_reg <= duty_stg_next;
      if (load) duty_act_reg <= duty_stg_next;
      pwm_reg <= ena ? (raw ^ pol_act) : pol_act;
    end
  end

endmodule

// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM: shared prescaler and edge/center-aligned period counter
// feeding CHANNELS comparators. Optional polarity via `define PWM_POLARITY_EN.
module pwm_multi_gen
  import pwm_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int ADDR_W   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                cfg_we,
  input  logic [ADDR_W-1:0]   cfg_addr,
  input  logic [WIDTH-1:0]    cfg_data,
  input  logic                center_mode,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_tick
);

  logic [WIDTH-1:0] period_stg_reg, period_stg_next, period_act_reg;
  logic [WIDTH-1:0] prescale_stg_reg, prescale_stg_next, prescale_act_reg;
  logic [WIDTH-1:0] psc_reg, psc_next;
  logic [WIDTH-1:0] cnt_reg, cnt_next;
  mode_e            mode_reg, mode_next;
  dir_e             dir_reg, dir_next;
  logic             tick;
  logic             boundary;
  logic             center_eff;
  logic             turning_down;
  logic             load;
  logic             period_tick_reg;

  assign period_stg_next   = (cfg_we && cfg_addr == ADDR_W'(ADDR_PERIOD))   ? cfg_data : period_stg_reg;
  assign prescale_stg_next = (cfg_we && cfg_addr == ADDR_W'(ADDR_PRESCALE)) ? cfg_data : prescale_stg_reg;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_stg_reg   <= '0;
      period_act_reg   <= '0;
      prescale_stg_reg <= '0;
      prescale_act_reg <= '0;
      psc_reg          <= '0;
      cnt_reg          <= '0;
      mode_reg         <= MODE_EDGE;
      dir_reg          <= DIR_UP;
      period_tick_reg  <= 1'b0;
    end else begin
      period_stg_reg   <= period_stg_next;
      prescale_stg_reg <= prescale_stg_next;
      if (load) begin
        period_act_reg   <= period_stg_next;
        prescale_act_reg <= prescale_stg_next;
      end
      psc_reg         <= psc_next;
      cnt_reg         <= cnt_next;
      mode_reg        <= mode_next;
      dir_reg         <= dir_next;
      period_tick_reg <= boundary;
    end
  end

  // Next-state: prescaler, counter and direction
  always_comb begin
    psc_next     = psc_reg;
    cnt_next     = cnt_reg;
    dir_next     = dir_reg;
    boundary     = 1'b0;
    // Center mode with period 0 degenerates to an edge counter stuck at 0.
    center_eff   = (mode_reg == MODE_CENTER) && (period_act_reg != '0);
    turning_down = (dir_reg == DIR_DOWN) || (cnt_reg == period_act_reg);
    tick         = ena && (psc_reg == prescale_act_reg);
    if (!ena) begin
      psc_next = '0;
      cnt_next = '0;
      dir_next = DIR_UP;
    end else if (!tick) begin
      psc_next = psc_reg + WIDTH'(1);
    end else begin
      psc_next = '0;
      if (!center_eff) begin
        boundary = (cnt_reg == period_act_reg);
        cnt_next = boundary ? '0 : cnt_reg + WIDTH'(1);
        dir_next = DIR_UP;
      end else if (turning_down && cnt_reg == WIDTH'(1)) begin
        boundary = 1'b1;
        cnt_next = '0;
        dir_next = DIR_UP;
      end else if (turning_down) begin
        cnt_next = cnt_reg - WIDTH'(1);
        dir_next = DIR_DOWN;
      end else begin
        cnt_next = cnt_reg + WIDTH'(1);
      end
    end
  end

  // Active-copy load control; disabled block tracks staged config every cycle
  always_comb begin
    load      = !ena || boundary;
    mode_next = mode_reg;
    if (load) mode_next = center_mode ? MODE_CENTER : MODE_EDGE;
  end

  assign period_tick = period_tick_reg;

`ifdef PWM_POLARITY_EN
  logic pol_we;
  assign pol_we = cfg_we && (cfg_addr == ADDR_W'(CHANNELS + ADDR_POLARITY_OFS));
`endif

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      pwm_channel #(
        .WIDTH(WIDTH)
      ) u_ch (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .load     (load),
        .duty_we  (cfg_we && (cfg_addr == ADDR_W'(ADDR_DUTY_BASE + gi))),
        .duty_data(cfg_data),
`ifdef PWM_POLARITY_EN
        .pol_we   (pol_we),
        .pol_data (cfg_data[gi]),
`endif
        .cnt      (cnt_reg),
        .pwm_out  (pwm_out[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_pwm_multi_gen.sv
// Scoreboard bench for pwm_multi_gen: a clock-index reference model predicts
// pwm_out/period_tick each edge; a monitor compares on the falling edge.
module tb_pwm_multi_gen;

  localparam int W  = 8;
  localparam int CH = 4;
  localparam int AW = 4;

  logic          clk;
  logic          rst_n;
  logic          ena;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [W-1:0]  cfg_data;
  logic          center_mode;
  logic [CH-1:0] pwm_out;
  logic          period_tick;

  pwm_multi_gen #(.WIDTH(W), .CHANNELS(CH), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .center_mode(center_mode), .pwm_out(pwm_out),
    .period_tick(period_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH-1:0] pwm;
    logic          tick;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Next-cycle input values, applied on the falling edge
  logic rstn_nx = 1'b0;
  logic ena_nx  = 1'b0;
  logic cm_nx   = 1'b0;

  // Reference model: config plus clock index within the current period
  int unsigned per_s, psc_s, per_a, psc_a, t;
  int unsigned duty_s[CH];
  int unsigned duty_a[CH];
  bit          pol_s[CH];
  bit          pol_a[CH];
  bit          center_a;

  function automatic int unsigned period_len();
    int unsigned ticks;
    ticks = (center_a && per_a != 0) ? 2 * per_a : per_a + 1;
    return ticks * (psc_a + 1);
  endfunction

  function automatic int unsigned model_cnt();
    int unsigned k;
    k = t / (psc_a + 1);
    if (!center_a || per_a == 0) return k;
    return (k <= per_a) ? k : 2 * per_a - k;
  endfunction

  function automatic void model_reset();
    per_s = 0; psc_s = 0; per_a = 0; psc_a = 0; t = 0; center_a = 1'b0;
    for (int c = 0; c < CH; c++) begin
      duty_s[c] = 0; duty_a[c] = 0; pol_s[c] = 1'b0; pol_a[c] = 1'b0;
    end
  endfunction

  function automatic void model_step();
    exp_t        e;
    bit          bnd;
    int unsigned c;
    int unsigned a;
    bnd = 1'b0;
    e   = '0;
    if (!rst_n) begin
      model_reset();
      sb_q.push_back(e);
      return;
    end
    if (!ena) begin
      for (int i = 0; i < CH; i++) e.pwm[i] = pol_a[i];
    end else begin
      c = model_cnt();
      for (int i = 0; i < CH; i++) e.pwm[i] = (c < duty_a[i]) ^ pol_a[i];
      bnd    = (t == period_len() - 1);
      e.tick = bnd;
    end
    if (cfg_we) begin
      a = cfg_addr;
      if (a == 0) per_s = cfg_data;
      else if (a == 1) psc_s = cfg_data;
      else if (a >= 2 && a < 2 + CH) duty_s[a - 2] = cfg_data;
`ifdef PWM_POLARITY_EN
      else if (a == 2 + CH) for (int i = 0; i < CH; i++) pol_s[i] = cfg_data[i];
`endif
    end
    if (!ena || bnd) begin
      per_a = per_s; psc_a = psc_s; center_a = center_mode; t = 0;
      for (int i = 0; i < CH; i++) begin
        duty_a[i] = duty_s[i]; pol_a[i] = pol_s[i];
      end
    end else begin
      t++;
    end
    sb_q.push_back(e);
  endfunction

  // Monitor: pop and compare one expectation per falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if (pwm_out !== e.pwm) begin
          errors++;
          $display("FAIL pwm_out @%0t: got %b, expected %b", $time, pwm_out, e.pwm);
        end
        checks++;
        if (period_tick !== e.tick) begin
          errors++;
          $display("FAIL period_tick @%0t: got %b, expected %b", $time, period_tick, e.tick);
        end
      end
    end
  end

  task automatic cyc(input bit we, input int a, input int d);
    @(negedge clk);
    rst_n       = rstn_nx;
    ena         = ena_nx;
    center_mode = cm_nx;
    cfg_we      = we;
    cfg_addr    = AW'(a);
    cfg_data    = W'(d);
    if (we) $display("write addr=%0d data=%0d ena=%0b center=%0b", a, d, ena, center_mode);
    @(posedge clk);
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 0);
  endtask

  // Directed duty-cycle count over a window spanning whole periods
  task automatic window(input int n, input int ch, input int exp_hi, input int exp_ticks);
    int hi;
    int tk;
    hi = 0;
    tk = 0;
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 0, 0);
      #1;
      hi += int'(pwm_out[ch]);
      tk += int'(period_tick);
    end
    checks++;
    if (hi != exp_hi) begin
      errors++;
      $display("FAIL window_high ch%0d: got %0d, expected %0d", ch, hi, exp_hi);
    end
    checks++;
    if (tk != exp_ticks) begin
      errors++;
      $display("FAIL window_ticks ch%0d: got %0d, expected %0d", ch, tk, exp_ticks);
    end
  endtask

  task automatic mid_reset();
    #2;
    rst_n   = 1'b0;
    rstn_nx = 1'b0;
    sb_q.delete();
    model_reset();
    #1;
    checks++;
    if (pwm_out !== '0 || period_tick !== 1'b0) begin
      errors++;
      $display("FAIL async_clear: got pwm=%b tick=%b, expected 0/0", pwm_out, period_tick);
    end
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; center_mode = 1'b0;
    model_reset();
    idle(3);
    rstn_nx = 1'b1; ena_nx = 1'b1;
    idle(5);

    // Edge mode, period 10 clocks
    cyc(1'b1, 0, 9);
    cyc(1'b1, 2, 3);
    cyc(1'b1, 3, 0);
    cyc(1'b1, 4, 10);
    cyc(1'b1, 5, 5);
    idle(12);
    window(10, 0, 3, 1);
    window(10, 1, 0, 1);
    window(10, 2, 10, 1);
    window(10, 3, 5, 1);

    // Mid-period duty change, then a write landing on a boundary
    for (int i = 0; i < 40 && t != 5; i++) cyc(1'b0, 0, 0);
    cyc(1'b1, 2, 7);
    idle(25);
    for (int i = 0; i < 40 && t != period_len() - 1; i++) cyc(1'b0, 0, 0);
    cyc(1'b1, 2, 2);
    idle(15);

    // Center mode, 32-clock period
    cm_nx = 1'b1;
    cyc(1'b1, 0, 8);
    cyc(1'b1, 1, 1);
    cyc(1'b1, 2, 4);
    idle(80);

    // Disable mid-period with writes while idle, then re-enable
    cm_nx = 1'b0;
    idle(7);
    ena_nx = 1'b0;
    cyc(1'b1, 0, 9);
    cyc(1'b1, 1, 0);
    cyc(1'b1, 2, 3);
    idle(4);
    ena_nx = 1'b1;
    idle(25);

`ifdef PWM_POLARITY_EN
    cyc(1'b1, 2 + CH, 1);
    idle(25);
    ena_nx = 1'b0;
    idle(5);
    ena_nx = 1'b1;
    idle(5);
`endif

    // Asynchronous reset mid-period, resume from zeroed config
    idle(6);
    mid_reset();
    idle(3);
    rstn_nx = 1'b1;
    idle(8);

    // Randomized phases
    for (int ph = 0; ph < 24; ph++) begin
      cm_nx = 1'($urandom_range(0, 1));
      cyc(1'b1, 0, int'($urandom_range(0, 12)));
      cyc(1'b1, 1, int'($urandom_range(0, 3)));
      for (int c = 0; c < CH; c++) cyc(1'b1, 2 + c, int'($urandom_range(0, 14)));
      if ($urandom_range(0, 3) == 0) cyc(1'b1, int'($urandom_range(6, 15)), int'($urandom_range(0, 255)));
      for (int i = 0; i < 60; i++) begin
        if ($urandom_range(0, 29) == 0) ena_nx = ~ena_nx;
        if ($urandom_range(0, 19) == 0) cyc(1'b1, int'($urandom_range(0, 5)), int'($urandom_range(0, 14)));
        else cyc(1'b0, 0, 0);
      end
      if (ph == 11) begin
        mid_reset();
        idle(2);
        rstn_nx = 1'b1;
      end
      ena_nx = 1'b1;
    end

    idle(2);
    @(negedge clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
